// File: rtl/plab5_mcore_mem_resp_buf.sv
// plab5_mcore_mem_resp_buf: security-tagged memory response queue that drops heads above the consumer level
module plab5_mcore_mem_resp_buf #(
    parameter  int p_opaque_nbits = 8,
    parameter  int p_data_nbits   = 32,
    parameter  int p_num_entries  = 4,
    localparam int resp_cnbits    = 3 + p_opaque_nbits + $clog2(p_data_nbits/8)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [resp_cnbits-1:0]  in_control,
    input  logic [p_data_nbits-1:0] in_data,
    input  logic                    in_sec_level,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic                    out_consumer_level,
    output logic [resp_cnbits-1:0]  out_control,
    output logic [p_data_nbits-1:0] out_data,
    output logic                    out_sec_level,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [7:0]              drop_count
);
    localparam int pw = $clog2(p_num_entries);
    logic [resp_cnbits-1:0]  ctrl_q [p_num_entries];
    logic [p_data_nbits-1:0] data_q [p_num_entries];
    logic                    sec_q  [p_num_entries];
    logic [pw-1:0]           wr_ptr;
    logic [pw-1:0]           rd_ptr;
    logic [pw:0]             count;
    logic                    nonempty;
    logic                    head_sec;
    logic                    eligible;
    logic                    drop;
    logic                    enq;
    logic                    pop;
    // Head eligibility, handshakes and registered-only output data
    always_comb begin
        nonempty      = count != '0;
        head_sec      = sec_q[rd_ptr];
        eligible      = nonempty && (head_sec <= out_consumer_level);
        drop          = nonempty && !eligible;
        in_rdy        = count != (pw+1)'(p_num_entries);
        out_val       = eligible;
        out_control   = nonempty ? ctrl_q[rd_ptr] : '0;
        out_sec_level = nonempty ? head_sec : 1'b0;
        out_data      = eligible ? data_q[rd_ptr] : '0;
        enq           = in_val && in_rdy;
        pop           = (eligible && out_rdy) || drop;
    end
    // Storage write; unknown tags are stored as high so they can never reach a low consumer
    always_ff @(posedge clk) begin
        if (enq) begin
            ctrl_q[wr_ptr] <= in_control;
            data_q[wr_ptr] <= in_data;
            sec_q[wr_ptr]  <= (in_sec_level === 1'b0) ? 1'b0 : 1'b1;
        end
    end
    // Pointers, occupancy and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{pw{1'b0}}, enq} - {{pw{1'b0}}, pop};
            if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
        end
    end
endmodule
